// File: rtl/scan_crypt_gasket.sv
// Scan-path to block-cipher bridge: SIPO -> hold -> core handshake -> result FIFO -> PISO.
// Block width, output buffer depth and block counter width are parameters.
//
// state  | meaning
// C_IDLE | no request outstanding; issues the hold block when the FIFO has room
// C_WAIT | core_req/core_din held stable until the core pulses core_ack
module scan_crypt_gasket #(
  parameter int BLK_W      = 128,
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             tck,
  input  logic             reset_n,
  input  logic             sync_clr,
  input  logic             bypass,
  input  logic             shift_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             core_req,
  output logic [BLK_W-1:0] core_din,
  input  logic             core_ack,
  input  logic [BLK_W-1:0] core_dout,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             ovf,
  output logic             urun,
  output logic             busy
);

  localparam int BIT_W = $clog2(BLK_W);
  localparam int PTR_W = $clog2(OBUF_DEPTH);

  typedef enum logic {
    C_IDLE = 1'b0,
    C_WAIT = 1'b1
  } c_state_t;

  c_state_t c_state, c_next;

  logic [BLK_W-2:0] sipo;
  logic [BIT_W-1:0] bit_cnt;
  logic [BLK_W-1:0] hold;
  logic             hold_valid;

  logic [BLK_W-1:0] fifo_mem [OBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;

  // piso keeps only the bits not yet presented; the current bit lives in scan_out
  logic [BLK_W-2:0] piso;
  logic [BIT_W-1:0] piso_idx;
  logic             piso_valid;

  logic             shift_act, sipo_done, fifo_full, fifo_empty;
  logic             issue, push, pop, piso_last;
  logic [BLK_W-1:0] sipo_blk;

  assign shift_act  = shift_en & ~bypass;
  assign sipo_blk   = {sipo, scan_in};
  assign sipo_done  = shift_act & (bit_cnt == BIT_W'(BLK_W - 1));
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(OBUF_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign piso_last  = shift_act & piso_valid & (piso_idx == '0);
  assign pop        = ~bypass & ~fifo_empty & (~piso_valid | piso_last);
  assign busy       = hold_valid | core_req | ~fifo_empty | piso_valid;

  always_comb begin
    c_next = c_state;
    issue  = 1'b0;
    push   = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (hold_valid && !fifo_full && !bypass) begin
          issue  = 1'b1;
          c_next = C_WAIT;
        end
      end
      C_WAIT: begin
        if (core_ack) begin
          push   = 1'b1;
          c_next = C_IDLE;
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      c_state  <= C_IDLE;
      core_req <= 1'b0;
      core_din <= '0;
    end else if (sync_clr) begin
      c_state  <= C_IDLE;
      core_req <= 1'b0;
      core_din <= '0;
    end else begin
      c_state <= c_next;
      if (issue) begin
        core_req <= 1'b1;
        core_din <= hold;
      end else if (push) begin
        core_req <= 1'b0;
      end
    end
  end

  // A block completing on the same edge the hold register is issued is accepted.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sipo       <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (sync_clr) begin
      sipo       <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (shift_act) begin
        sipo    <= sipo_blk[BLK_W-2:0];
        bit_cnt <= sipo_done ? '0 : bit_cnt + BIT_W'(1);
      end
      if (sipo_done && (!hold_valid || issue)) begin
        hold       <= sipo_blk;
        hold_valid <= 1'b1;
      end else if (issue) begin
        hold_valid <= 1'b0;
      end
      if (sipo_done && hold_valid && !issue) ovf <= 1'b1;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      blk_cnt  <= '0;
    end else if (sync_clr) begin
      for (int i = 0; i < OBUF_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      blk_cnt  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= core_dout;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        blk_cnt          <= blk_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      piso       <= '0;
      piso_idx   <= '0;
      piso_valid <= 1'b0;
      scan_out   <= 1'b0;
      urun       <= 1'b0;
    end else if (sync_clr) begin
      piso       <= '0;
      piso_idx   <= '0;
      piso_valid <= 1'b0;
      scan_out   <= 1'b0;
      urun       <= 1'b0;
    end else begin
      if (bypass) begin
        if (shift_en) scan_out <= scan_in;
      end else if (pop) begin
        piso       <= fifo_mem[rd_ptr][BLK_W-2:0];
        scan_out   <= fifo_mem[rd_ptr][BLK_W-1];
        piso_idx   <= BIT_W'(BLK_W - 1);
        piso_valid <= 1'b1;
      end else if (shift_en && piso_valid) begin
        piso     <= {piso[BLK_W-3:0], 1'b0};
        scan_out <= piso[BLK_W-2];
        if (piso_idx == '0) piso_valid <= 1'b0;
        else                piso_idx   <= piso_idx - BIT_W'(1);
      end else if (shift_en) begin
        scan_out <= 1'b0;
      end
      if (shift_act && !piso_valid) urun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_crypt_gasket.sv
// Directed bench for scan_crypt_gasket (BLK_W=8, OBUF_DEPTH=2) with a behavioural
// cipher core (dout = din ^ 8'hFF) and a core_din scoreboard.
module tb_scan_crypt_gasket;

  logic       tck = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       bypass = 1'b0;
  logic       shift_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       core_ack = 1'b0;
  logic [7:0] core_dout = 8'h00;
  logic       scan_out, core_req, ovf, urun, busy;
  logic [7:0] core_din;
  logic [15:0] blk_cnt;

  scan_crypt_gasket #(.BLK_W(8), .OBUF_DEPTH(2), .CNT_W(16)) dut (
    .tck(tck), .reset_n(reset_n), .sync_clr(sync_clr), .bypass(bypass),
    .shift_en(shift_en), .scan_in(scan_in), .scan_out(scan_out),
    .core_req(core_req), .core_din(core_din), .core_ack(core_ack),
    .core_dout(core_dout), .blk_cnt(blk_cnt), .ovf(ovf), .urun(urun), .busy(busy)
  );

  always #5 tck = ~tck;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_din_q[$];
  logic       cap_q[$];
  logic       cap_en = 1'b0;
  int         ack_delay = 3;
  logic       pending = 1'b0;
  int         ack_cnt = 0;
  logic       prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // behavioural core: acks ack_delay cycles after it sees a new request
  initial begin
    forever begin
      @(negedge tck);
      if (!reset_n) begin
        pending  = 1'b0;
        core_ack = 1'b0;
      end else if (core_ack) begin
        core_ack = 1'b0;
        pending  = 1'b0;
      end else if (!pending && core_req) begin
        pending = 1'b1;
        ack_cnt = ack_delay;
      end else if (pending) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          core_ack  = 1'b1;
          core_dout = core_din ^ 8'hFF;
        end
      end
    end
  end

  // scoreboard monitor: every new request must carry the next expected block
  initial begin
    forever begin
      @(negedge tck);
      #1;
      if (core_req && !prev_req) begin
        if (exp_din_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL core_din: unexpected issue of %0h, expected none", core_din);
        end else begin
          check("core_din", 32'(core_din), 32'(exp_din_q.pop_front()));
        end
      end
      prev_req = core_req;
    end
  end

  // bit presented on scan_out at each shifting edge
  initial begin
    forever begin
      @(negedge tck);
      #1;
      if (cap_en && shift_en && !bypass) cap_q.push_back(scan_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      scan_in  = v[i];
      shift_en = 1'b1;
      @(negedge tck);
    end
    shift_en = 1'b0;
    scan_in  = 1'b0;
  endtask

  task automatic do_clr();
    sync_clr = 1'b1;
    @(negedge tck);
    sync_clr = 1'b0;
  endtask

  task automatic wait_req_fall(input string name);
    int k = 0;
    while (core_req && k < 100) begin
      @(negedge tck);
      k++;
    end
    check({name, "_req_fall_timeout"}, 32'(core_req), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < 300) begin
      @(negedge tck);
      k++;
      if (!core_req && !pending && !core_ack) quiet++;
      else quiet = 0;
    end
    check({name, "_idle_timeout"}, 32'(quiet >= 3), 32'd1);
    check({name, "_issues_left"}, 32'(exp_din_q.size()), 32'd0);
  endtask

  task automatic wait_blk(input string name, input logic [15:0] target, input int budget);
    int k = 0;
    while (blk_cnt != target && k < budget) begin
      @(negedge tck);
      k++;
    end
    check({name, "_blk_cnt"}, 32'(blk_cnt), 32'(target));
  endtask

  task automatic readout(input string name, input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("%s_bit%0d", name, i), 32'(scan_out), 32'(exp[i]));
      if (i > 0) begin
        shift_en = 1'b1;
        @(negedge tck);
        shift_en = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_scan_out"}, 32'(scan_out), 32'd0);
    check({name, "_core_req"}, 32'(core_req), 32'd0);
    check({name, "_core_din"}, 32'(core_din), 32'd0);
    check({name, "_blk_cnt"},  32'(blk_cnt),  32'd0);
    check({name, "_ovf"},      32'(ovf),      32'd0);
    check({name, "_urun"},     32'(urun),     32'd0);
    check({name, "_busy"},     32'(busy),     32'd0);
  endtask

  logic [23:0] stream;
  int          first_one;

  initial begin
    // reset state
    repeat (2) @(negedge tck);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge tck);

    // single block A5 -> 5A, request one cycle after the 8th bit
    exp_din_q.push_back(8'hA5);
    shift_bits(32'hA5, 8);
    check("t1_req_before", 32'(core_req), 32'd0);
    @(negedge tck);
    check("t1_req_after", 32'(core_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_req_fall("t1");
    @(negedge tck);
    check("t1_blk_cnt", 32'(blk_cnt), 32'd1);
    readout("t1_out", 8'h5A);
    wait_idle("t1");

    // three back-to-back blocks, gapless output stream
    do_clr();
    cap_q.delete();
    cap_en = 1'b1;
    exp_din_q.push_back(8'h3C);
    exp_din_q.push_back(8'hC3);
    exp_din_q.push_back(8'h0F);
    shift_bits(32'h3C, 8);
    shift_bits(32'hC3, 8);
    shift_bits(32'h0F, 8);
    wait_blk("t2", 16'd3, 60);
    check("t2_ovf", 32'(ovf), 32'd0);
    exp_din_q.push_back(8'h00);
    shift_bits(32'h0, 15);
    cap_en = 1'b0;
    first_one = -1;
    for (int i = 0; i < cap_q.size(); i++)
      if (first_one < 0 && cap_q[i]) first_one = i;
    stream = '0;
    if (first_one >= 0 && first_one + 24 <= cap_q.size())
      for (int i = 0; i < 24; i++) stream[23-i] = cap_q[first_one+i];
    check("t2_stream", 32'(stream), 32'hC33CF0);
    wait_idle("t2");

    // slow core: third block finds hold occupied and is dropped
    do_clr();
    ack_delay = 40;
    exp_din_q.push_back(8'h11);
    exp_din_q.push_back(8'h22);
    shift_bits(32'h11, 8);
    shift_bits(32'h22, 8);
    shift_bits(32'h33, 8);
    check("t3_ovf_set", 32'(ovf), 32'd1);
    wait_blk("t3", 16'd2, 200);
    repeat (20) @(negedge tck);
    check("t3_blk_cnt_final", 32'(blk_cnt), 32'd2);
    check("t3_ovf_sticky", 32'(ovf), 32'd1);
    wait_idle("t3");
    ack_delay = 3;

    // underrun with empty output side, then synchronous clear
    do_clr();
    check("t4_urun_clr", 32'(urun), 32'd0);
    for (int i = 0; i < 4; i++) begin
      scan_in  = 1'b1;
      shift_en = 1'b1;
      @(negedge tck);
      check($sformatf("t4_scan_out%0d", i), 32'(scan_out), 32'd0);
    end
    shift_en = 1'b0;
    scan_in  = 1'b0;
    check("t4_urun", 32'(urun), 32'd1);
    do_clr();
    check("t4_urun_after_clr", 32'(urun), 32'd0);
    check("t4_blk_cnt_after_clr", 32'(blk_cnt), 32'd0);

    // bypass: one-cycle pass-through, cipher path untouched
    bypass = 1'b1;
    begin
      logic [3:0] pat;
      pat = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
        scan_in  = pat[i];
        shift_en = 1'b1;
        @(negedge tck);
        check($sformatf("t5_bypass%0d", i), 32'(scan_out), 32'(pat[i]));
        check($sformatf("t5_req%0d", i), 32'(core_req), 32'd0);
      end
    end
    shift_en = 1'b0;
    scan_in  = 1'b0;
    bypass   = 1'b0;
    @(negedge tck);
    check("t5_urun", 32'(urun), 32'd0);

    // asynchronous reset during an outstanding request, then a fresh round trip
    do_clr();
    exp_din_q.push_back(8'h81);
    shift_bits(32'h81, 8);
    @(negedge tck);
    check("t6_req_up", 32'(core_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    repeat (2) @(negedge tck);
    reset_n = 1'b1;
    @(negedge tck);
    exp_din_q.push_back(8'h81);
    shift_bits(32'h81, 8);
    @(negedge tck);
    check("t6_req_again", 32'(core_req), 32'd1);
    wait_req_fall("t6");
    @(negedge tck);
    check("t6_blk_cnt", 32'(blk_cnt), 32'd1);
    readout("t6_out", 8'h7E);
    wait_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_crypt_gasket.md
Name: scan_crypt_gasket

Overview:
- Parametrised serial-to-block-to-serial bridge between a scan path (TDI side) and an external block-cipher core (encrypt or decrypt).
- Deserialises BLK_W scan bits into a block and hands it to the core over a req/ack handshake.
- Buffers core results in an OBUF_DEPTH-entry FIFO and reserialises them onto scan_out.
- Successor to the fixed 128-bit decrypt/encrypt wrapper: width, buffer depth and bypass are configurable; overflow, underrun and block counting are new.

Parameters:
- BLK_W, 128, cipher block width in bits (≥8).
- OBUF_DEPTH, 2, output FIFO depth in blocks (power of 2, ≥2).
- CNT_W, 16, width of the processed-block counter.

Ports:
- tck  in  1  scan clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous clear of all state, including sticky flags.
- bypass  in  1  1: scan_out = scan_in delayed one cycle; cipher path frozen.
- shift_en  in  1  qualifies scan_in sampling and scan_out advance.
- scan_in  in  1  serial data in, MSB first.
- scan_out  out  1  serial data out, MSB first.
- core_req  out  1  block valid to cipher core.
- core_din  out  BLK_W  block to cipher core.
- core_ack  in  1  core result valid, one-cycle pulse.
- core_dout  in  BLK_W  core result; valid when core_ack=1.
- blk_cnt  out  CNT_W  blocks written to the FIFO; wraps.
- ovf  out  1  sticky: input block dropped.
- urun  out  1  sticky: shift with no output data.
- busy  out  1  hold_valid | core_req | FIFO non-empty | piso_valid.

Behaviour:
- Reset (async) and sync_clr: all registers 0. scan_out=0, core_req=0, core_din=0, blk_cnt=0, ovf=0, urun=0, busy=0. sync_clr has priority over all other inputs.
- SIPO: on shift_en & !bypass, sipo <= {sipo[BLK_W-2:0], scan_in} and the bit counter increments.
  - On the BLK_W-th bit, the counter wraps to 0.
  - If hold_valid=0: hold <= completed block, hold_valid <= 1.
  - Else: block dropped, ovf <= 1.
- Core FSM, states C_IDLE and C_WAIT:
  - C_IDLE → C_WAIT when hold_valid & FIFO not full. At the same edge: core_req <= 1, core_din <= hold, hold_valid <= 0. The hold register is then free for the next block.
  - C_WAIT: core_req and core_din held stable. core_ack is ignored outside C_WAIT.
  - On core_ack: FIFO push core_dout, blk_cnt +1 (wrap), core_req <= 0, → C_IDLE.
  - Fullness is checked before issue, so the push never overflows.
- Latency: block completes at edge N → core_req high after edge N+1 (earliest).
- PISO: when piso_valid=0 and FIFO non-empty, pop the head into piso at the next edge, piso_valid <= 1, bit index = BLK_W-1.
  - scan_out is registered: scan_out <= piso MSB at load and after each shift.
  - Each shift_en with piso_valid shifts left one bit.
  - After the last bit, if the FIFO is non-empty it reloads in the same edge (gapless stream); otherwise piso_valid <= 0.
- Underrun: shift_en & !piso_valid & !bypass → scan_out <= 0, urun <= 1.
- Simultaneous events:
  - FIFO push and pop in the same cycle are both honoured.
  - SIPO completion in the same cycle hold is freed: the new block is accepted (no ovf).
- bypass=1: scan_out <= scan_in every cycle with shift_en. SIPO, FIFO and PISO hold their state; the core FSM still completes an outstanding handshake.
- Reset mid-operation: core_req drops immediately; the core must tolerate an abandoned request.

Test Plan (BLK_W=8, OBUF_DEPTH=2; core model returns din^8'hFF, ack 3 cycles after req):
- Shift 8'hA5 with shift_en continuous → core_din=8'hA5; core_req rises 1 cycle after the 8th bit; blk_cnt=1; after the PISO load and 8 shifts, scan_out bits are 0,1,0,1,1,0,1,0 (8'h5A).
- Shift 8'h3C, 8'hC3, 8'h0F back-to-back, then continuous shift → output stream 8'hC3, 8'h3C, 8'hF0 with no gap bits; ovf=0; blk_cnt=3.
- Core model with ack delay 40 cycles, shift three blocks back-to-back → the third block is dropped; ovf=1; blk_cnt ends at 2.
- shift_en for 4 cycles with an empty FIFO → scan_out=0 throughout; urun=1; then sync_clr pulse → urun=0, blk_cnt=0.
- bypass=1, scan_in pattern 1,1,0,1 → scan_out shows 1,1,0,1 one cycle later; core_req stays 0.
- Assert reset_n=0 while core_req=1 mid-handshake → all outputs 0 asynchronously; after release, a fresh 8'h81 round-trips to 8'h7E.
